mult_unit: RTL and testbench

MULT_UNIT -- requirements
Module: mult_unit

---
 rtl/mult_unit.sv | 100 ++++++++++
 tb/tb_mult_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_unit.sv
// Sequential 32x32 shift-add multiplier (mult/multu) writing a 64-bit product into HI/LO.
// Latency: start in cycle N gives done in N+34; no backpressure, starts while busy are dropped.
module mult_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        startMult,
    input  logic        signedMult,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic [1:0]  mfReg,
    output logic [31:0] mfResult,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        neg_res;
    logic        signed_q;
    logic [63:0] acc;
    logic [4:0]  count;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] addend;
    logic [63:0] product;

    // 0x80000000 negates to itself, which read unsigned is exactly 2^31
    assign abs_a   = (signedMult && srca[31]) ? (~srca + 32'd1) : srca;
    assign abs_b   = (signedMult && srcb[31]) ? (~srcb + 32'd1) : srcb;
    assign addend  = mag_b[count] ? ({32'd0, mag_a} << count) : 64'd0;
    assign product = (signed_q && neg_res) ? (~acc + 64'd1) : acc;

    assign busy = (state != IDLE);

    always_comb begin
        mfResult = 32'd0;
        case (mfReg)
            2'b10:   mfResult = hi;
            2'b01:   mfResult = lo;
            default: mfResult = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mag_a    <= 32'd0;
            mag_b    <= 32'd0;
            neg_res  <= 1'b0;
            signed_q <= 1'b0;
            acc      <= 64'd0;
            count    <= 5'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (startMult) begin
                        mag_a    <= abs_a;
                        mag_b    <= abs_b;
                        neg_res  <= signedMult & (srca[31] ^ srcb[31]);
                        signed_q <= signedMult;
                        acc      <= 64'd0;
                        count    <= 5'd0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc + addend;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    hi    <= product[63:32];
                    lo    <= product[31:0];
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit: vector table run back-to-back plus ignored-start,
// mid-run reset, reset-vs-start priority and mfReg select sequences.
module tb_mult_unit;

    logic        clk;
    logic        reset;
    logic        startMult;
    logic        signedMult;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [1:0]  mfReg;
    logic [31:0] mfResult;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;

    typedef struct {
        logic        sm;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t vecs [12];

    mult_unit dut (
        .clk        (clk),
        .reset      (reset),
        .startMult  (startMult),
        .signedMult (signedMult),
        .srca       (srca),
        .srcb       (srcb),
        .mfReg      (mfReg),
        .mfResult   (mfResult),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at the negedge of the done cycle.
    task automatic run_vec(input logic sm, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
        logic ok;
        signedMult = sm;
        srca       = a;
        srcb       = b;
        startMult  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        startMult  = 1'b0;
        srca       = 32'hDEAD_BEEF;
        srcb       = 32'h0BAD_F00D;
        signedMult = ~sm;
        ok = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            if (k > 1) @(negedge clk);
            if (busy !== (k <= 33) || done !== (k == 34)) ok = 1'b0;
            if (k < 34 && (hi !== mdl_hi || lo !== mdl_lo)) ok = 1'b0;
        end
        chk("latency_busy_done_hold", {63'd0, ok}, 64'd1);
        mdl_hi = exp[63:32];
        mdl_lo = exp[31:0];
        chk("hi", {32'd0, hi}, {32'd0, mdl_hi});
        chk("lo", {32'd0, lo}, {32'd0, mdl_lo});
        mfReg = 2'b10;
        #1 chk("mf_hi", {32'd0, mfResult}, {32'd0, mdl_hi});
        mfReg = 2'b01;
        #1 chk("mf_lo", {32'd0, mfResult}, {32'd0, mdl_lo});
        mfReg = 2'b00;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;

        vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1]  = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[2]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[3]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[4]  = '{1'b0, 32'h0000_0003, 32'h0000_0007, 64'h0000_0000_0000_0015};
        vecs[5]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
        vecs[6]  = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
        vecs[7]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
        vecs[9]  = '{1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};
        vecs[10] = '{1'b1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001};
        vecs[11] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE};

        reset      = 1'b1;
        startMult  = 1'b0;
        signedMult = 1'b0;
        srca       = 32'd0;
        srcb       = 32'd0;
        mfReg      = 2'b10;
        mdl_hi     = 32'd0;
        mdl_lo     = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hi_lo", {hi, lo}, 64'd0);
        chk("reset_mf", {32'd0, mfResult}, 64'd0);
        mfReg = 2'b00;

        // Back-to-back: each new start lands in the previous done cycle.
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // Start ignored while busy.
        @(negedge clk);
        signedMult = 1'b0;
        srca       = 32'd3;
        srcb       = 32'd7;
        startMult  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        startMult = 1'b0;
        busy_cnt  = 0;
        done_cnt  = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (k == 5) begin
                srca      = 32'd2;
                srcb      = 32'd2;
                startMult = 1'b1;
            end else begin
                startMult = 1'b0;
            end
        end
        chk("ignored_start_busy_cycles", 64'(busy_cnt), 64'd33);
        chk("ignored_start_done_pulses", 64'(done_cnt), 64'd1);
        chk("ignored_start_hi_lo", {hi, lo}, 64'd21);

        // Reset in the middle of RUN.
        srca      = 32'd6;
        srcb      = 32'd7;
        startMult = 1'b1;
        @(posedge clk);
        @(negedge clk);
        startMult = 1'b0;
        for (int k = 2; k <= 10; k++) @(negedge clk);
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrun_reset_busy", {63'd0, busy}, 64'd0);
        chk("midrun_reset_hi_lo", {hi, lo}, 64'd0);
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            @(negedge clk);
        end
        chk("midrun_reset_no_done", 64'(done_cnt), 64'd0);
        chk("midrun_reset_stays_idle", 64'(busy_cnt), 64'd0);
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;

        // Reset and start together: start dropped.
        srca      = 32'd5;
        srcb      = 32'd5;
        reset     = 1'b1;
        startMult = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        startMult = 1'b0;
        busy_cnt  = 0;
        for (int k = 0; k < 3; k++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        chk("reset_beats_start", 64'(busy_cnt), 64'd0);

        // Read-select decode with distinct HI and LO words.
        run_vec(1'b0, 32'h1234_5678, 32'h0001_0000, 64'h0000_1234_5678_0000);
        mfReg = 2'b00;
        #1 chk("mf_sel_00", {32'd0, mfResult}, 64'd0);
        mfReg = 2'b11;
        #1 chk("mf_sel_11", {32'd0, mfResult}, 64'd0);
        mfReg = 2'b10;
        #1 chk("mf_sel_10", {32'd0, mfResult}, 64'h0000_0000_0000_1234);
        mfReg = 2'b01;
        #1 chk("mf_sel_01", {32'd0, mfResult}, 64'h0000_0000_5678_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
